// File: rtl/fast_command_pkg.sv
// Shared fast-command definitions: codewords, one-hot indices, FSM states and decode result.
// Used by the decoder as well as by the generator and checker.
package fast_command_pkg;

  localparam int NUM_CMDS = 10;

  typedef logic [7:0]          symbol_t;
  typedef logic [NUM_CMDS-1:0] onehot_t;

  localparam symbol_t CW_IDLE        = 8'hF0;
  localparam symbol_t CW_LINK_RESET  = 8'h33;
  localparam symbol_t CW_BCR         = 8'h5A;
  localparam symbol_t CW_SYNC_TRIG   = 8'h55;
  localparam symbol_t CW_L1A_CR      = 8'h66;
  localparam symbol_t CW_CHARGE_INJ  = 8'h69;
  localparam symbol_t CW_L1A         = 8'h96;
  localparam symbol_t CW_L1A_BCR     = 8'h99;
  localparam symbol_t CW_WS_START    = 8'hA5;
  localparam symbol_t CW_WS_STOP     = 8'hAA;

  localparam int IDX_IDLE       = 0;
  localparam int IDX_LINK_RESET = 1;
  localparam int IDX_BCR        = 2;
  localparam int IDX_SYNC_TRIG  = 3;
  localparam int IDX_L1A_CR     = 4;
  localparam int IDX_CHARGE_INJ = 5;
  localparam int IDX_L1A        = 6;
  localparam int IDX_L1A_BCR    = 7;
  localparam int IDX_WS_START   = 8;
  localparam int IDX_WS_STOP    = 9;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } fc_state_t;

  typedef struct packed {
    logic    valid;
    logic    corrected;
    onehot_t onehot;
  } decode_t;

  function automatic symbol_t codeword(input int idx);
    case (idx)
      IDX_IDLE:       return CW_IDLE;
      IDX_LINK_RESET: return CW_LINK_RESET;
      IDX_BCR:        return CW_BCR;
      IDX_SYNC_TRIG:  return CW_SYNC_TRIG;
      IDX_L1A_CR:     return CW_L1A_CR;
      IDX_CHARGE_INJ: return CW_CHARGE_INJ;
      IDX_L1A:        return CW_L1A;
      IDX_L1A_BCR:    return CW_L1A_BCR;
      IDX_WS_START:   return CW_WS_START;
      IDX_WS_STOP:    return CW_WS_STOP;
      default:        return 8'h00;
    endcase
  endfunction

  function automatic int hamming8(input symbol_t a, input symbol_t b);
    return $countones(a ^ b);
  endfunction

endpackage

// File: rtl/fc_symbol_decode.sv
// Combinational symbol -> {valid, corrected, onehot} decoder.
// FCD_HAMMING_CORRECT_EN enables single-bit-error correction; default build accepts exact matches only.
module fc_symbol_decode
  import fast_command_pkg::*;
(
  input  symbol_t symbol,
  output decode_t result
);

  onehot_t exact;

`ifdef FCD_HAMMING_CORRECT_EN
  onehot_t near;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    exact  = '0;
    near   = '0;
    result = '0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      exact[i] = (symbol == codeword(i));
      near[i]  = (hamming8(symbol, codeword(i)) == 1);
    end
    if (|exact) begin
      result.valid  = 1'b1;
      result.onehot = exact;
    end else if ($onehot(near)) begin
      // Codewords sit 4 apart, so a single flipped bit points at exactly one of them.
      result.valid     = 1'b1;
      result.corrected = 1'b1;
      result.onehot    = near;
    end
  end
`else
  always_comb begin
    exact  = '0;
    result = '0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      exact[i] = (symbol == codeword(i));
    end
    result.valid  = |exact;
    result.onehot = exact;
  end
`endif

endmodule

// File: rtl/fast_command_decoder.sv
// Serial fast-command receiver: aligns on IDLE, qualifies lock, decodes each 8-bit frame to one-hot.
// Optional macro FCD_HAMMING_CORRECT_EN turns on single-bit correction and the corrCount counter.
module fast_command_decoder
  import fast_command_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 4,
  parameter int ERRCNT_WIDTH = 16
) (
  input  logic                    clk320,
  input  logic                    reset,
  input  logic                    clearCount,
  input  logic                    fcDataIn,
  output logic [NUM_CMDS-1:0]     fcd,
  output logic                    fcdValid,
  output logic [7:0]              fcByte,
  output logic                    locked,
  output logic [ERRCNT_WIDTH-1:0] errCount,
  output logic [ERRCNT_WIDTH-1:0] corrCount
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int RUN_W  = $clog2(UNLOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(UNLOCK_COUNT - 1);

  symbol_t           sr;
  logic [2:0]        bit_cnt, bit_cnt_d;
  fc_state_t         state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              frame_end;
  logic              publish;
  logic              err_inc;
  logic              corr_inc;
  decode_t           dec;

  fc_symbol_decode u_decode (
    .symbol (sr),
    .result (dec)
  );

  assign frame_end = (bit_cnt == 3'd7);
  assign locked    = (state_q == ST_LOCKED);

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    run_d     = run_q;
    bit_cnt_d = bit_cnt + 3'd1;
    publish   = 1'b0;
    err_inc   = 1'b0;
    corr_inc  = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        // The aligning IDLE already counts as the first good frame.
        if (sr == CW_IDLE) begin
          state_d   = ST_CHECK;
          good_d    = GOOD_W'(1);
          bit_cnt_d = 3'd0;
        end
      end

      ST_CHECK: begin
        if (frame_end) begin
          if (dec.valid) begin
            corr_inc = dec.corrected;
            if (good_q == GOOD_LAST) begin
              state_d = ST_LOCKED;
              good_d  = '0;
              run_d   = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            state_d = ST_SEARCH;
            good_d  = '0;
          end
        end
      end

      ST_LOCKED: begin
        if (frame_end) begin
          publish = 1'b1;
          if (dec.valid) begin
            corr_inc = dec.corrected;
            run_d    = '0;
          end else begin
            err_inc = 1'b1;
            if (run_q == RUN_LAST) begin
              state_d = ST_SEARCH;
              run_d   = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end
        end
      end

      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk320 or negedge reset) begin
    if (!reset) begin
      sr       <= '0;
      bit_cnt  <= '0;
      state_q  <= ST_SEARCH;
      good_q   <= '0;
      run_q    <= '0;
      fcd      <= '0;
      fcdValid <= 1'b0;
      fcByte   <= '0;
      errCount <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples pre-edge values.
      sr       <= {sr[6:0], fcDataIn};
      bit_cnt  <= bit_cnt_d;
      state_q  <= state_d;
      good_q   <= good_d;
      run_q    <= run_d;
      fcdValid <= publish;
      if (publish) begin
        // An invalid frame decodes to an all-zero one-hot, which also clears fcd on unlock.
        fcd    <= dec.onehot;
        fcByte <= sr;
      end
      if (clearCount) begin
        errCount <= '0;
      end else if (err_inc && !(&errCount)) begin
        errCount <= errCount + 1'b1;
      end
    end
  end

`ifdef FCD_HAMMING_CORRECT_EN
  always_ff @(posedge clk320 or negedge reset) begin
    if (!reset) begin
      corrCount <= '0;
    end else if (clearCount) begin
      corrCount <= '0;
    end else if (corr_inc && !(&corrCount)) begin
      corrCount <= corrCount + 1'b1;
    end
  end
`else
  logic unused_corr;
  assign unused_corr = corr_inc;
  assign corrCount   = '0;
`endif

endmodule

// File: tb/tb_fast_command_decoder.sv
// Directed bench for fast_command_decoder: lock, decode, correction, unlock, bit slip, saturation, reset.
// A second instance with a 3-bit error counter exercises counter saturation.
module tb_fast_command_decoder;

  logic        clk320     = 1'b0;
  logic        reset      = 1'b0;
  logic        clearCount = 1'b0;
  logic        fcDataIn   = 1'b0;

  logic [9:0]  fcd;
  logic        fcdValid;
  logic [7:0]  fcByte;
  logic        locked;
  logic [15:0] errCount;
  logic [15:0] corrCount;

  logic [9:0]  s_fcd;
  logic        s_fcd_valid;
  logic [7:0]  s_fc_byte;
  logic        s_locked;
  logic [2:0]  s_err;
  logic [2:0]  s_corr;

  int total   = 0;
  int bad     = 0;
  int exp_err = 0;
  int exp_sat = 0;

  logic [9:0]  obs_fcd, obs_hold;
  logic        obs_v0, obs_v1, obs_v2, obs_locked;
  logic [7:0]  obs_byte;
  logic [15:0] obs_err, obs_corr;
  logic [2:0]  obs_serr;

  fast_command_decoder dut (
    .clk320     (clk320),
    .reset      (reset),
    .clearCount (clearCount),
    .fcDataIn   (fcDataIn),
    .fcd        (fcd),
    .fcdValid   (fcdValid),
    .fcByte     (fcByte),
    .locked     (locked),
    .errCount   (errCount),
    .corrCount  (corrCount)
  );

  fast_command_decoder #(.ERRCNT_WIDTH(3)) dut_sat (
    .clk320     (clk320),
    .reset      (reset),
    .clearCount (clearCount),
    .fcDataIn   (fcDataIn),
    .fcd        (s_fcd),
    .fcdValid   (s_fcd_valid),
    .fcByte     (s_fc_byte),
    .locked     (s_locked),
    .errCount   (s_err),
    .corrCount  (s_corr)
  );

  always #5 clk320 = ~clk320;

  task automatic send_bit(input logic b);
    @(negedge clk320);
    fcDataIn = b;
  endtask

  // Sends one frame MSB first; the outputs captured here describe the previously sent frame.
  task automatic send_frame(input logic [7:0] b, input logic clr);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk320);
      if (i == 0) begin
        obs_v0     = fcdValid;
        clearCount = clr;
      end
      if (i == 1) begin
        obs_fcd    = fcd;
        obs_v1     = fcdValid;
        obs_byte   = fcByte;
        obs_locked = locked;
        obs_err    = errCount;
        obs_corr   = corrCount;
        obs_serr   = s_err;
        clearCount = 1'b0;
      end
      if (i == 2) obs_v2 = fcdValid;
      if (i == 7) obs_hold = fcd;
      fcDataIn = b[7-i];
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk320);
    total++; if (fcd !== 10'h000) begin bad++; $display("FAIL reset_fcd: got %h want 000", fcd); end
    total++; if (fcdValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", fcdValid); end
    total++; if (fcByte !== 8'h00) begin bad++; $display("FAIL reset_byte: got %h want 00", fcByte); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    total++; if (errCount !== 16'h0 || corrCount !== 16'h0) begin bad++; $display("FAIL reset_counts: got err %h corr %h want 0 0", errCount, corrCount); end
    reset = 1'b1;
  endtask

  task automatic test_lock_offset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (4) send_frame(8'hF0, 1'b0);
    total++; if (obs_locked !== 1'b0) begin bad++; $display("FAIL lock_early: got %b want 0", obs_locked); end
    send_frame(8'hF0, 1'b0);
    total++; if (obs_locked !== 1'b1) begin bad++; $display("FAIL lock_after_4: got %b want 1", obs_locked); end
    total++; if (obs_v1 !== 1'b0 || obs_fcd !== 10'h000) begin bad++; $display("FAIL lock_no_output: got valid %b fcd %h want 0 000", obs_v1, obs_fcd); end
    send_frame(8'hF0, 1'b0);
    total++; if (obs_fcd !== 10'h001) begin bad++; $display("FAIL lock_idle_fcd: got %h want 001", obs_fcd); end
    total++; if (obs_v1 !== 1'b1 || obs_byte !== 8'hF0) begin bad++; $display("FAIL lock_idle_strobe: got valid %b byte %h want 1 F0", obs_v1, obs_byte); end
  endtask

  task automatic test_decode();
    send_frame(8'h5A, 1'b0);
    send_frame(8'h99, 1'b0);
    total++; if (obs_fcd !== 10'h004) begin bad++; $display("FAIL bcr_fcd: got %h want 004", obs_fcd); end
    total++; if (obs_v0 !== 1'b0 || obs_v1 !== 1'b1 || obs_v2 !== 1'b0) begin bad++; $display("FAIL bcr_strobe: got %b%b%b want 010", obs_v0, obs_v1, obs_v2); end
    total++; if (obs_hold !== 10'h004) begin bad++; $display("FAIL bcr_hold: got %h want 004", obs_hold); end
    total++; if (obs_byte !== 8'h5A) begin bad++; $display("FAIL bcr_byte: got %h want 5A", obs_byte); end
    send_frame(8'hF0, 1'b0);
    total++; if (obs_fcd !== 10'h080 || obs_byte !== 8'h99) begin bad++; $display("FAIL l1a_bcr: got fcd %h byte %h want 080 99", obs_fcd, obs_byte); end
    total++; if (obs_hold !== 10'h080) begin bad++; $display("FAIL l1a_bcr_hold: got %h want 080", obs_hold); end
  endtask

  task automatic test_bit_flip();
    send_frame(8'h97, 1'b0);
    send_frame(8'hF0, 1'b0);
    total++; if (obs_v1 !== 1'b1 || obs_byte !== 8'h97 || obs_locked !== 1'b1) begin bad++; $display("FAIL flip_strobe: got valid %b byte %h locked %b want 1 97 1", obs_v1, obs_byte, obs_locked); end
`ifdef FCD_HAMMING_CORRECT_EN
    total++; if (obs_fcd !== 10'h040) begin bad++; $display("FAIL flip_fcd: got %h want 040", obs_fcd); end
    total++; if (obs_corr !== 16'd1 || obs_err !== 16'd0) begin bad++; $display("FAIL flip_counts: got corr %0d err %0d want 1 0", obs_corr, obs_err); end
`else
    exp_err = exp_err + 1;
    total++; if (obs_fcd !== 10'h000) begin bad++; $display("FAIL flip_fcd: got %h want 000", obs_fcd); end
    total++; if (obs_corr !== 16'd0 || obs_err !== 16'(exp_err)) begin bad++; $display("FAIL flip_counts: got corr %0d err %0d want 0 %0d", obs_corr, obs_err, exp_err); end
`endif
  endtask

  task automatic test_unlock_zeros();
    send_frame(8'h00, 1'b0);
    send_frame(8'h00, 1'b0);
    total++; if (obs_fcd !== 10'h000 || obs_err !== 16'(exp_err + 1) || obs_locked !== 1'b1) begin bad++; $display("FAIL zero1: got fcd %h err %0d locked %b want 000 %0d 1", obs_fcd, obs_err, obs_locked, exp_err + 1); end
    send_frame(8'h00, 1'b0);
    send_frame(8'h00, 1'b0);
    total++; if (obs_locked !== 1'b1 || obs_err !== 16'(exp_err + 3)) begin bad++; $display("FAIL zero3_still_locked: got locked %b err %0d want 1 %0d", obs_locked, obs_err, exp_err + 3); end
    send_frame(8'hF0, 1'b0);
    exp_err = exp_err + 4;
    total++; if (obs_locked !== 1'b0 || obs_fcd !== 10'h000 || obs_err !== 16'(exp_err)) begin bad++; $display("FAIL zero4_unlock: got locked %b fcd %h err %0d want 0 000 %0d", obs_locked, obs_fcd, obs_err, exp_err); end
    repeat (3) send_frame(8'hF0, 1'b0);
    total++; if (obs_locked !== 1'b0) begin bad++; $display("FAIL relock_early: got %b want 0", obs_locked); end
    send_frame(8'hF0, 1'b0);
    total++; if (obs_locked !== 1'b1 || obs_v1 !== 1'b0) begin bad++; $display("FAIL relock: got locked %b valid %b want 1 0", obs_locked, obs_v1); end
    send_frame(8'hF0, 1'b0);
    total++; if (obs_fcd !== 10'h001 || obs_v1 !== 1'b1) begin bad++; $display("FAIL relock_idle: got fcd %h valid %b want 001 1", obs_fcd, obs_v1); end
  endtask

  task automatic test_bit_slip();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    repeat (4) send_frame(8'hF0, 1'b0);
    total++; if (obs_locked !== 1'b1 || obs_err !== 16'(exp_err + 3)) begin bad++; $display("FAIL slip_3: got locked %b err %0d want 1 %0d", obs_locked, obs_err, exp_err + 3); end
    send_frame(8'hF0, 1'b0);
    exp_err = exp_err + 4;
    total++; if (obs_locked !== 1'b0 || obs_fcd !== 10'h000 || obs_err !== 16'(exp_err)) begin bad++; $display("FAIL slip_unlock: got locked %b fcd %h err %0d want 0 000 %0d", obs_locked, obs_fcd, obs_err, exp_err); end
    repeat (3) send_frame(8'hF0, 1'b0);
    total++; if (obs_locked !== 1'b1) begin bad++; $display("FAIL slip_relock: got %b want 1", obs_locked); end
    send_frame(8'hF0, 1'b0);
    total++; if (obs_fcd !== 10'h001 || obs_v0 !== 1'b0 || obs_v1 !== 1'b1 || obs_byte !== 8'hF0) begin bad++; $display("FAIL slip_phase: got fcd %h v0 %b v1 %b byte %h want 001 0 1 F0", obs_fcd, obs_v0, obs_v1, obs_byte); end
  endtask

  task automatic test_saturate_reset_clear();
    exp_sat = (exp_err > 7) ? 7 : exp_err;
    total++; if (errCount !== 16'(exp_err) || s_err !== 3'(exp_sat)) begin bad++; $display("FAIL sat_level: got err %0d sat %0d want %0d %0d", errCount, s_err, exp_err, exp_sat); end
    send_frame(8'h00, 1'b0);
    send_frame(8'hF0, 1'b0);
    exp_err = exp_err + 1;
    total++; if (obs_err !== 16'(exp_err) || obs_serr !== 3'd7) begin bad++; $display("FAIL sat_hold: got err %0d sat %0d want %0d 7", obs_err, obs_serr, exp_err); end
    send_frame(8'hF0, 1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    total++; if (locked !== 1'b1 || fcd !== 10'h001) begin bad++; $display("FAIL pre_reset: got locked %b fcd %h want 1 001", locked, fcd); end
    #1 reset = 1'b0;
    #1;
    total++; if (fcd !== 10'h000 || fcdValid !== 1'b0 || fcByte !== 8'h00 || locked !== 1'b0) begin bad++; $display("FAIL async_reset_out: got fcd %h valid %b byte %h locked %b want all 0", fcd, fcdValid, fcByte, locked); end
    total++; if (errCount !== 16'h0 || corrCount !== 16'h0 || s_err !== 3'd0) begin bad++; $display("FAIL async_reset_cnt: got err %0d corr %0d sat %0d want 0 0 0", errCount, corrCount, s_err); end
    exp_err = 0;
    repeat (2) @(negedge clk320);
    reset = 1'b1;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    repeat (5) send_frame(8'hF0, 1'b0);
    send_frame(8'h00, 1'b0);
    total++; if (obs_fcd !== 10'h001 || obs_locked !== 1'b1) begin bad++; $display("FAIL reset_relock: got fcd %h locked %b want 001 1", obs_fcd, obs_locked); end
    send_frame(8'hF0, 1'b1);
    total++; if (obs_err !== 16'd0 || obs_serr !== 3'd0 || obs_fcd !== 10'h000) begin bad++; $display("FAIL clear_wins: got err %0d sat %0d fcd %h want 0 0 000", obs_err, obs_serr, obs_fcd); end
    send_frame(8'hF0, 1'b0);
    total++; if (obs_err !== 16'd0 || obs_fcd !== 10'h001) begin bad++; $display("FAIL after_clear: got err %0d fcd %h want 0 001", obs_err, obs_fcd); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lock_offset();
    test_decode();
    test_bit_flip();
    test_unlock_zeros();
    test_bit_slip();
    test_saturate_reset_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
